// File: rtl/aw_w_scheduler.sv
// Write-path sequencer for master M1: decodes AW targets, gates the AW handshake,
// and keeps W and B mux selects in accepted-AW order. Sinks default-target writes.
module aw_w_scheduler #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_SIZE = 32'h0001_0000,
    parameter logic [31:0] S1_BASE = 32'h0001_0000,
    parameter logic [31:0] S1_SIZE = 32'h0001_0000,
    parameter int          DEPTH   = 4,
    parameter int          MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AWADDR_M1,
    input  logic        AWVALID_M1,
    output logic        AWREADY_M1,
    output logic        AWVALID_S0,
    input  logic        AWREADY_S0,
    output logic        AWVALID_S1,
    input  logic        AWREADY_S1,
    input  logic        WVALID_M1,
    input  logic        WREADY_M1,
    input  logic        WLAST_M1,
    output logic [1:0]  w_sel,
    output logic        dflt_wready,
    input  logic        BVALID_S0,
    input  logic        BVALID_S1,
    input  logic        BREADY_M1,
    output logic [1:0]  b_sel,
    output logic        dflt_bvalid,
    output logic        busy
);

    localparam int WAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW  = $clog2(MAX_OUT + 1);

    localparam logic [WAW:0]   WDEPTH_C = (WAW + 1)'(DEPTH);
    localparam logic [CW-1:0]  MAXOUT_C = CW'(MAX_OUT);
    localparam logic [BAW-1:0] BLAST_C  = BAW'(MAX_OUT - 1);

    // Windows are compared in 33 bits so a window ending at 2^32 does not wrap.
    localparam logic [32:0] S0_LO = {1'b0, S0_BASE};
    localparam logic [32:0] S0_HI = {1'b0, S0_BASE} + {1'b0, S0_SIZE};
    localparam logic [32:0] S1_LO = {1'b0, S1_BASE};
    localparam logic [32:0] S1_HI = {1'b0, S1_BASE} + {1'b0, S1_SIZE};

    logic [32:0]   addr33;
    logic [1:0]    tgt;
    logic          accept_ok;
    logic          aw_hs;
    logic          w_pop;
    logic          b_hs;

    logic [1:0]    wmem_q [DEPTH];
    logic [WAW-1:0] wwr_q, wwr_d, wrd_q, wrd_d;
    logic [WAW:0]   wcnt_q, wcnt_d;

    logic [1:0]    bmem_q [MAX_OUT];
    logic [BAW-1:0] bwr_q, bwr_d, brd_q, brd_d;
    logic [CW-1:0]  bcnt_q, bcnt_d;

    logic [CW-1:0]  out_cnt_q, out_cnt_d;

    always_comb begin
        addr33 = {1'b0, AWADDR_M1};
        if (addr33 >= S0_LO && addr33 < S0_HI) begin
            tgt = 2'b01;
        end else if (addr33 >= S1_LO && addr33 < S1_HI) begin
            tgt = 2'b10;
        end else begin
            tgt = 2'b11;
        end
    end

    // A same-cycle W pop does not free space for the AW that is being presented.
    assign accept_ok  = (wcnt_q != WDEPTH_C) && (out_cnt_q < MAXOUT_C);
    assign AWVALID_S0 = AWVALID_M1 & (tgt == 2'b01) & accept_ok;
    assign AWVALID_S1 = AWVALID_M1 & (tgt == 2'b10) & accept_ok;
    assign AWREADY_M1 = accept_ok & ((tgt == 2'b01) ? AWREADY_S0 :
                                     (tgt == 2'b10) ? AWREADY_S1 : 1'b1);
    assign aw_hs      = AWVALID_M1 & AWREADY_M1;

    assign w_sel       = (wcnt_q != '0) ? wmem_q[wrd_q] : 2'b00;
    assign dflt_wready = (w_sel == 2'b11);
    assign w_pop       = WVALID_M1 & WREADY_M1 & WLAST_M1 & (w_sel != 2'b00);

    assign b_sel       = (bcnt_q != '0) ? bmem_q[brd_q] : 2'b00;
    assign dflt_bvalid = (b_sel == 2'b11);
    assign b_hs        = BREADY_M1 & ((b_sel == 2'b01) ? BVALID_S0 :
                                      (b_sel == 2'b10) ? BVALID_S1 :
                                      (b_sel == 2'b11));

    assign busy = (out_cnt_q != '0);

    always_comb begin
        wwr_d     = wwr_q;
        wrd_d     = wrd_q;
        wcnt_d    = wcnt_q;
        bwr_d     = bwr_q;
        brd_d     = brd_q;
        bcnt_d    = bcnt_q;
        out_cnt_d = out_cnt_q;
        if (aw_hs) wwr_d = wwr_q + WAW'(1);
        if (w_pop) wrd_d = wrd_q + WAW'(1);
        case ({aw_hs, w_pop})
            2'b10:   wcnt_d = wcnt_q + (WAW + 1)'(1);
            2'b01:   wcnt_d = wcnt_q - (WAW + 1)'(1);
            default: wcnt_d = wcnt_q;
        endcase
        // B pointers wrap explicitly because MAX_OUT need not be a power of two.
        if (w_pop) bwr_d = (bwr_q == BLAST_C) ? '0 : bwr_q + BAW'(1);
        if (b_hs)  brd_d = (brd_q == BLAST_C) ? '0 : brd_q + BAW'(1);
        case ({w_pop, b_hs})
            2'b10:   bcnt_d = bcnt_q + CW'(1);
            2'b01:   bcnt_d = bcnt_q - CW'(1);
            default: bcnt_d = bcnt_q;
        endcase
        case ({aw_hs, b_hs})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wwr_q     <= '0;
            wrd_q     <= '0;
            wcnt_q    <= '0;
            bwr_q     <= '0;
            brd_q     <= '0;
            bcnt_q    <= '0;
            out_cnt_q <= '0;
        end else begin
            wwr_q     <= wwr_d;
            wrd_q     <= wrd_d;
            wcnt_q    <= wcnt_d;
            bwr_q     <= bwr_d;
            brd_q     <= brd_d;
            bcnt_q    <= bcnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Storage needs no reset: the counts guard every read.
    always_ff @(posedge clk) begin
        if (aw_hs) wmem_q[wwr_q] <= tgt;
        if (w_pop) bmem_q[bwr_q] <= w_sel;
    end

endmodule

// File: tb/tb_aw_w_scheduler.sv
// Directed testbench for aw_w_scheduler: one task per scenario, inline checks,
// single summary line at the end.
module tb_aw_w_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] AWADDR_M1;
    logic        AWVALID_M1;
    logic        AWREADY_M1;
    logic        AWVALID_S0;
    logic        AWREADY_S0;
    logic        AWVALID_S1;
    logic        AWREADY_S1;
    logic        WVALID_M1;
    logic        WREADY_M1;
    logic        WLAST_M1;
    logic [1:0]  w_sel;
    logic        dflt_wready;
    logic        BVALID_S0;
    logic        BVALID_S1;
    logic        BREADY_M1;
    logic [1:0]  b_sel;
    logic        dflt_bvalid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    aw_w_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .AWADDR_M1   (AWADDR_M1),
        .AWVALID_M1  (AWVALID_M1),
        .AWREADY_M1  (AWREADY_M1),
        .AWVALID_S0  (AWVALID_S0),
        .AWREADY_S0  (AWREADY_S0),
        .AWVALID_S1  (AWVALID_S1),
        .AWREADY_S1  (AWREADY_S1),
        .WVALID_M1   (WVALID_M1),
        .WREADY_M1   (WREADY_M1),
        .WLAST_M1    (WLAST_M1),
        .w_sel       (w_sel),
        .dflt_wready (dflt_wready),
        .BVALID_S0   (BVALID_S0),
        .BVALID_S1   (BVALID_S1),
        .BREADY_M1   (BREADY_M1),
        .b_sel       (b_sel),
        .dflt_bvalid (dflt_bvalid),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        AWADDR_M1  = 32'h0;
        AWVALID_M1 = 1'b0;
        AWREADY_S0 = 1'b0;
        AWREADY_S1 = 1'b0;
        WVALID_M1  = 1'b0;
        WREADY_M1  = 1'b0;
        WLAST_M1   = 1'b0;
        BVALID_S0  = 1'b0;
        BVALID_S1  = 1'b0;
        BREADY_M1  = 1'b0;
    endtask

    task automatic wlast(input logic on);
        WVALID_M1 = on;
        WREADY_M1 = on;
        WLAST_M1  = on;
    endtask

    // Reset state with no traffic.
    task automatic test_reset();
        idle();
        rst = 1'b0;
        #2;
        checks++; if (w_sel !== 2'b00) begin $display("[TB] FAIL reset_w_sel got %b exp 00", w_sel); errors++; end
        checks++; if (b_sel !== 2'b00) begin $display("[TB] FAIL reset_b_sel got %b exp 00", b_sel); errors++; end
        checks++; if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy got %b exp 0", busy); errors++; end
        checks++; if ({dflt_wready, dflt_bvalid} !== 2'b00) begin $display("[TB] FAIL reset_dflt got %b exp 00", {dflt_wready, dflt_bvalid}); errors++; end
        checks++; if ({AWVALID_S0, AWVALID_S1} !== 2'b00) begin $display("[TB] FAIL reset_awvalid got %b exp 00", {AWVALID_S0, AWVALID_S1}); errors++; end
        step();
        rst = 1'b1;
        step();
    endtask

    // Single S0 write through AW, W, B.
    task automatic test_single_s0();
        AWADDR_M1 = 32'h0000_0010; AWVALID_M1 = 1'b1; AWREADY_S0 = 1'b1;
        #1;
        checks++; if ({AWVALID_S0, AWVALID_S1, AWREADY_M1} !== 3'b101) begin $display("[TB] FAIL s0_aw got %b exp 101", {AWVALID_S0, AWVALID_S1, AWREADY_M1}); errors++; end
        checks++; if (w_sel !== 2'b00) begin $display("[TB] FAIL s0_no_bypass got %b exp 00", w_sel); errors++; end
        step();
        idle();
        #1;
        checks++; if (w_sel !== 2'b01) begin $display("[TB] FAIL s0_w_sel got %b exp 01", w_sel); errors++; end
        checks++; if (busy !== 1'b1) begin $display("[TB] FAIL s0_busy got %b exp 1", busy); errors++; end
        wlast(1'b1);
        step();
        wlast(1'b0);
        #1;
        checks++; if ({w_sel, b_sel} !== 4'b0001) begin $display("[TB] FAIL s0_after_w got %b exp 0001", {w_sel, b_sel}); errors++; end
        BVALID_S0 = 1'b1; BREADY_M1 = 1'b1;
        step();
        idle();
        #1;
        checks++; if ({b_sel, busy} !== 3'b000) begin $display("[TB] FAIL s0_done got %b exp 000", {b_sel, busy}); errors++; end
    endtask

    // Unmapped address goes to the internal default target.
    task automatic test_default();
        AWADDR_M1 = 32'h0002_0000; AWVALID_M1 = 1'b1;
        #1;
        checks++; if ({AWVALID_S0, AWVALID_S1, AWREADY_M1} !== 3'b001) begin $display("[TB] FAIL dflt_aw got %b exp 001", {AWVALID_S0, AWVALID_S1, AWREADY_M1}); errors++; end
        step();
        idle();
        #1;
        checks++; if ({w_sel, dflt_wready} !== 3'b111) begin $display("[TB] FAIL dflt_w got %b exp 111", {w_sel, dflt_wready}); errors++; end
        wlast(1'b1);
        step();
        wlast(1'b0);
        #1;
        checks++; if ({dflt_bvalid, dflt_wready} !== 2'b10) begin $display("[TB] FAIL dflt_b got %b exp 10", {dflt_bvalid, dflt_wready}); errors++; end
        step();
        checks++; if (dflt_bvalid !== 1'b1) begin $display("[TB] FAIL dflt_b_hold got %b exp 1", dflt_bvalid); errors++; end
        BREADY_M1 = 1'b1;
        step();
        idle();
        #1;
        checks++; if ({dflt_bvalid, busy} !== 2'b00) begin $display("[TB] FAIL dflt_done got %b exp 00", {dflt_bvalid, busy}); errors++; end
    endtask

    // S1 then S0: W and B follow AW order, early S0 BVALID is held off.
    task automatic test_back_to_back();
        AWADDR_M1 = 32'h0001_0004; AWVALID_M1 = 1'b1; AWREADY_S1 = 1'b1;
        #1;
        checks++; if ({AWVALID_S0, AWVALID_S1} !== 2'b01) begin $display("[TB] FAIL b2b_aw1 got %b exp 01", {AWVALID_S0, AWVALID_S1}); errors++; end
        step();
        AWADDR_M1 = 32'h0000_0020; AWREADY_S0 = 1'b1; AWREADY_S1 = 1'b0;
        #1;
        checks++; if ({AWVALID_S0, AWVALID_S1, w_sel} !== 4'b1010) begin $display("[TB] FAIL b2b_aw2 got %b exp 1010", {AWVALID_S0, AWVALID_S1, w_sel}); errors++; end
        step();
        idle();
        WVALID_M1 = 1'b1; WREADY_M1 = 1'b1;
        step();
        checks++; if ({w_sel, b_sel} !== 4'b1000) begin $display("[TB] FAIL b2b_nonlast got %b exp 1000", {w_sel, b_sel}); errors++; end
        WLAST_M1 = 1'b1;
        step();
        wlast(1'b0);
        #1;
        checks++; if ({w_sel, b_sel} !== 4'b0110) begin $display("[TB] FAIL b2b_w_order got %b exp 0110", {w_sel, b_sel}); errors++; end
        wlast(1'b1); BVALID_S0 = 1'b1; BREADY_M1 = 1'b1;
        step();
        wlast(1'b0);
        #1;
        checks++; if ({w_sel, b_sel, busy} !== 5'b00101) begin $display("[TB] FAIL b2b_b_stall got %b exp 00101", {w_sel, b_sel, busy}); errors++; end
        step();
        checks++; if (b_sel !== 2'b10) begin $display("[TB] FAIL b2b_b_stall2 got %b exp 10", b_sel); errors++; end
        BVALID_S1 = 1'b1;
        step();
        BVALID_S1 = 1'b0;
        #1;
        checks++; if ({b_sel, busy} !== 3'b011) begin $display("[TB] FAIL b2b_b_next got %b exp 011", {b_sel, busy}); errors++; end
        step();
        idle();
        #1;
        checks++; if ({b_sel, busy} !== 3'b000) begin $display("[TB] FAIL b2b_done got %b exp 000", {b_sel, busy}); errors++; end
    endtask

    // Outstanding limit: fifth AW blocked until the first B handshake.
    task automatic test_max_out();
        AWADDR_M1 = 32'h0000_0100; AWVALID_M1 = 1'b1; AWREADY_S0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (AWREADY_M1 !== 1'b1) begin $display("[TB] FAIL max_accept%0d got %b exp 1", i, AWREADY_M1); errors++; end
            step();
        end
        #1;
        checks++; if ({AWREADY_M1, AWVALID_S0, AWVALID_S1} !== 3'b000) begin $display("[TB] FAIL max_block got %b exp 000", {AWREADY_M1, AWVALID_S0, AWVALID_S1}); errors++; end
        wlast(1'b1);
        step();
        wlast(1'b0);
        #1;
        checks++; if ({AWREADY_M1, AWVALID_S0, b_sel} !== 4'b0001) begin $display("[TB] FAIL max_block_wpop got %b exp 0001", {AWREADY_M1, AWVALID_S0, b_sel}); errors++; end
        BVALID_S0 = 1'b1; BREADY_M1 = 1'b1;
        #1;
        checks++; if (AWREADY_M1 !== 1'b0) begin $display("[TB] FAIL max_block_bhs got %b exp 0", AWREADY_M1); errors++; end
        step();
        BVALID_S0 = 1'b0; BREADY_M1 = 1'b0;
        #1;
        checks++; if ({AWREADY_M1, AWVALID_S0} !== 2'b11) begin $display("[TB] FAIL max_unblock got %b exp 11", {AWREADY_M1, AWVALID_S0}); errors++; end
        step();
        AWVALID_M1 = 1'b0;
        wlast(1'b1); BVALID_S0 = 1'b1; BREADY_M1 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        idle();
        #1;
        checks++; if ({w_sel, b_sel, busy} !== 5'b00000) begin $display("[TB] FAIL max_drain got %b exp 00000", {w_sel, b_sel, busy}); errors++; end
    endtask

    // AW accept and B handshake in the same cycle with two writes outstanding.
    task automatic test_same_cycle();
        AWADDR_M1 = 32'h0000_0010; AWVALID_M1 = 1'b1; AWREADY_S0 = 1'b1;
        step();
        AWADDR_M1 = 32'h0001_0000; AWREADY_S0 = 1'b0; AWREADY_S1 = 1'b1;
        step();
        idle();
        wlast(1'b1);
        step();
        wlast(1'b0);
        AWADDR_M1 = 32'h0003_0000; AWVALID_M1 = 1'b1;
        BVALID_S0 = 1'b1; BREADY_M1 = 1'b1;
        #1;
        checks++; if ({AWREADY_M1, b_sel, w_sel} !== 5'b10110) begin $display("[TB] FAIL sc_setup got %b exp 10110", {AWREADY_M1, b_sel, w_sel}); errors++; end
        step();
        idle();
        #1;
        checks++; if ({w_sel, b_sel, busy} !== 5'b10001) begin $display("[TB] FAIL sc_after got %b exp 10001", {w_sel, b_sel, busy}); errors++; end
        wlast(1'b1);
        step();
        checks++; if ({w_sel, b_sel, dflt_wready} !== 5'b11101) begin $display("[TB] FAIL sc_w1 got %b exp 11101", {w_sel, b_sel, dflt_wready}); errors++; end
        step();
        wlast(1'b0);
        #1;
        checks++; if ({w_sel, b_sel} !== 4'b0010) begin $display("[TB] FAIL sc_w2 got %b exp 0010", {w_sel, b_sel}); errors++; end
        BVALID_S1 = 1'b1; BREADY_M1 = 1'b1;
        step();
        BVALID_S1 = 1'b0;
        #1;
        checks++; if ({b_sel, dflt_bvalid, busy} !== 4'b1111) begin $display("[TB] FAIL sc_b1 got %b exp 1111", {b_sel, dflt_bvalid, busy}); errors++; end
        step();
        idle();
        #1;
        checks++; if ({b_sel, busy} !== 3'b000) begin $display("[TB] FAIL sc_done got %b exp 000", {b_sel, busy}); errors++; end
    endtask

    // Asynchronous reset with two writes in flight, then a clean S0 write.
    task automatic test_reset_mid();
        AWADDR_M1 = 32'h0000_0040; AWVALID_M1 = 1'b1; AWREADY_S0 = 1'b1;
        step();
        AWADDR_M1 = 32'h0002_0000;
        step();
        idle();
        wlast(1'b1);
        step();
        idle();
        #1;
        checks++; if ({w_sel, b_sel, busy} !== 5'b11011) begin $display("[TB] FAIL rm_pre got %b exp 11011", {w_sel, b_sel, busy}); errors++; end
        #1;
        rst = 1'b0;
        #1;
        checks++; if ({w_sel, b_sel, busy, dflt_wready, dflt_bvalid} !== 7'b0) begin $display("[TB] FAIL rm_flush got %b exp 0000000", {w_sel, b_sel, busy, dflt_wready, dflt_bvalid}); errors++; end
        rst = 1'b1;
        step();
        AWADDR_M1 = 32'h0000_0080; AWVALID_M1 = 1'b1; AWREADY_S0 = 1'b1;
        step();
        idle();
        #1;
        checks++; if (w_sel !== 2'b01) begin $display("[TB] FAIL rm_fresh_w got %b exp 01", w_sel); errors++; end
        wlast(1'b1);
        step();
        wlast(1'b0);
        #1;
        checks++; if ({w_sel, b_sel} !== 4'b0001) begin $display("[TB] FAIL rm_fresh_b got %b exp 0001", {w_sel, b_sel}); errors++; end
        BVALID_S0 = 1'b1; BREADY_M1 = 1'b1;
        step();
        idle();
        #1;
        checks++; if ({b_sel, busy} !== 3'b000) begin $display("[TB] FAIL rm_fresh_done got %b exp 000", {b_sel, busy}); errors++; end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_single_s0();
        test_default();
        test_back_to_back();
        test_max_out();
        test_same_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aw_w_scheduler.md
Name: aw_w_scheduler

Overview:
- Write-path sequencer for the AXI bridge's single write master M1.
- Decodes each AW request to S0, S1 or the internal default (DECERR) target, and gates the AW handshake.
- Records target order so the write-data mux (w_sel) and the write-response mux (b_sel) follow accepted AW order.
- Sinks write data for the default target and raises its B response. AW/W/B payload buses are routed outside this block.

Parameters:
S0_BASE, 32'h0000_0000, S0 window base
S0_SIZE, 32'h0001_0000, S0 window size in bytes
S1_BASE, 32'h0001_0000, S1 window base
S1_SIZE, 32'h0001_0000, S1 window size in bytes
DEPTH, 4, W-order FIFO entries (power of 2, ≥2)
MAX_OUT, 4, max writes accepted on AW but not yet completed on B; also B-order FIFO depth

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
AWADDR_M1  input  32  M1 write address
AWVALID_M1  input  1  M1 AW valid
AWREADY_M1  output  1  M1 AW ready
AWVALID_S0  output  1  AW valid to S0
AWREADY_S0  input  1  S0 AW ready
AWVALID_S1  output  1  AW valid to S1
AWREADY_S1  input  1  S1 AW ready
WVALID_M1  input  1  M1 W valid
WREADY_M1  input  1  muxed W ready seen by M1
WLAST_M1  input  1  M1 W last
w_sel  output  2  W mux select: 00 none, 01 S0, 10 S1, 11 default
dflt_wready  output  1  default-target W ready, muxed onto WREADY_M1 when w_sel=11
BVALID_S0  input  1  S0 B valid
BVALID_S1  input  1  S1 B valid
BREADY_M1  input  1  M1 B ready
b_sel  output  2  B mux select, same encoding; also gates BREADY to slaves
dflt_bvalid  output  1  default-target B valid; external mux drives BRESP=2'b11 (DECERR)
busy  output  1  one or more writes outstanding

Behaviour:
- Decode (combinational):
  - tgt=01 if S0_BASE ≤ AWADDR_M1 < S0_BASE+S0_SIZE.
  - Else tgt=10 if the address is in the S1 window.
  - Else tgt=11.
  - Compare in 33-bit arithmetic, so a window ending at 2^32 does not wrap.
- accept_ok = !wfifo_full && (out_cnt < MAX_OUT).
- AW path (combinational, zero latency):
  - AWVALID_Sx = AWVALID_M1 & (tgt==Sx) & accept_ok.
  - AWREADY_M1 = accept_ok & (tgt==01 ? AWREADY_S0 : tgt==10 ? AWREADY_S1 : 1).
  - AW handshake = AWVALID_M1 & AWREADY_M1. On handshake: push tgt into the W-order FIFO; out_cnt+1.
  - If not accept_ok: AWREADY_M1=0 and both AWVALID_Sx=0, even if a same-cycle W pop would free space.
- W path:
  - w_sel = W-FIFO head when non-empty, else 00. Registered, so an AW accepted in cycle N gives w_sel valid at N+1; no same-cycle bypass.
  - dflt_wready = (w_sel==11).
  - W pop = WVALID_M1 & WREADY_M1 & WLAST_M1 & (w_sel!=00). On pop: push the head code into the B-order FIFO.
  - Non-last beats leave the state unchanged.
- B path:
  - b_sel = B-FIFO head when non-empty, else 00.
  - dflt_bvalid = (b_sel==11).
  - B handshake = BREADY_M1 & (b_sel==01 ? BVALID_S0 : b_sel==10 ? BVALID_S1 : b_sel==11). On handshake: pop the B FIFO; out_cnt-1.
  - A BVALID from a slave that is not the head is ignored (stalled) until its turn.
- Counter and flags:
  - AW handshake and B handshake in the same cycle: out_cnt unchanged.
  - The B FIFO cannot overflow, since its depth is MAX_OUT.
  - busy = (out_cnt != 0).
- Simultaneous push/pop on either FIFO: count unchanged; head advances.
- Same-cycle empty-to-empty pass-through is not allowed.
- Reset (async, rst=0):
  - FIFOs empty, out_cnt=0.
  - w_sel=00, b_sel=00, dflt_wready=0, dflt_bvalid=0, busy=0.
  - AW outputs are 0 while AWVALID_M1=0.
  - Reset mid-burst flushes all tracking; no response is generated for flushed writes.

Test Plan:
- Single write to 0x0000_0010, len 0, S0 ready: AWVALID_S0=1 same cycle, w_sel=01 next cycle, WLAST handshake → b_sel=01; BVALID_S0 & BREADY_M1 → b_sel=00, busy=0.
- Write to 0x0002_0000 (unmapped): AWREADY_M1=1 with no slave valid; w_sel=11 and dflt_wready=1; after WLAST, dflt_bvalid=1 until BREADY_M1; out_cnt returns to 0.
- Back-to-back AW to S1 then S0: w_sel=10 until S1 WLAST, then 01; S0 BVALID asserted first is held (b_sel=10) until S1's B completes.
- Issue 4 AWs with W stalled (MAX_OUT=4): 5th AWVALID_M1 sees AWREADY_M1=0 and AWVALID_S0/S1=0 until the first B handshake.
- Same-cycle AW accept and B handshake at out_cnt=2: out_cnt stays 2, FIFO contents correct.
- Assert rst low with 2 writes in flight: w_sel, b_sel, busy, dflt_* go 0 immediately; a fresh S0 write afterwards completes normally.
